// File: rtl/trig_phase_hist.sv
// -----------------------------------------------------------------------------
// trig_phase_hist
//
// Trigger-phase histogrammer for the trigger board ADC clock domain.
// Once per measurement period (2^PERIOD_LOG2 cycles) an acquisition window of
// WINDOW_LEN cycles is opened. During the window, every trigger sample of each
// channel is counted into the bin selected by a free-running phase counter.
// The cycle after the window closes the histograms and per-channel lock flags
// are published. They hold until the next publish.
//
// Optional feature macro: TRIG_EDGE_EN
//   defined   : one count per rising edge of trig_in[c]
//   undefined : one count per cycle trig_in[c] is high
//
// Ports:
//   clk_adc    in   1                  sole clock, rising edge
//   nrst       in   1                  asynchronous active-low reset
//   trig_in    in   NCH                raw trigger levels (no synchroniser)
//   resethist  in   1                  synchronous restart of measurement
//   window     out  1                  high during acquisition cycles
//   done       out  1                  one-cycle pulse, new results valid
//   hist_out   out  NCH*NBINS*CW       channel c, bin b at (c*NBINS+b)*CW
//   lock       out  NCH                channel locked to a single bin
//   lock_bin   out  NCH*log2(NBINS)    locked bin per channel, 0 if unlocked
//   sat        out  NCH                some bin of the channel saturated
// -----------------------------------------------------------------------------
module trig_phase_hist #(
    parameter int NCH         = 4,
    parameter int NBINS       = 4,
    parameter int CW          = 8,
    parameter int PERIOD_LOG2 = 27,
    parameter int WINDOW_LEN  = 250,
    parameter int EXPECT_LO   = 54,
    parameter int EXPECT_HI   = 55
) (
    input  logic                           clk_adc,
    input  logic                           nrst,
    input  logic [NCH-1:0]                 trig_in,
    input  logic                           resethist,
    output logic                           window,
    output logic                           done,
    output logic [NCH*NBINS*CW-1:0]        hist_out,
    output logic [NCH-1:0]                 lock,
    output logic [NCH*$clog2(NBINS)-1:0]   lock_bin,
    output logic [NCH-1:0]                 sat
);

    localparam int BW = $clog2(NBINS);
    localparam int HW = NCH * NBINS * CW;
    localparam int NW = $clog2(NBINS + 1);

    localparam logic [CW-1:0]          CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]          BAND_LO  = CW'(EXPECT_LO);
    localparam logic [CW-1:0]          BAND_HI  = CW'(EXPECT_HI);
    localparam logic [PERIOD_LOG2-1:0] WIN_LAST = PERIOD_LOG2'(WINDOW_LEN - 1);
    localparam logic [PERIOD_LOG2-1:0] PCNT_MAX = {PERIOD_LOG2{1'b1}};

    typedef enum logic [1:0] {
        ST_ACQ  = 2'd0,
        ST_EVAL = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Bit offset of (channel, bin) inside the packed counter vector.
    function automatic int bin_base(input int ch, input int bin);
        return (ch * NBINS + bin) * CW;
    endfunction

    state_t                  state_q, state_d;
    logic [PERIOD_LOG2-1:0]  pcnt_q, pcnt_d;
    logic [BW-1:0]           ph_q, ph_d;
    logic [HW-1:0]           cnt_q, cnt_d;
    logic [NCH-1:0]          satf_q, satf_d;
    logic [NCH-1:0]          samp_s;

    logic                    window_q, window_d;
    logic                    done_q, done_d;
    logic [HW-1:0]           hist_q, hist_d;
    logic [NCH-1:0]          lock_q, lock_d;
    logic [NCH*BW-1:0]       lock_bin_q, lock_bin_d;
    logic [NCH-1:0]          sat_q, sat_d;

    logic [NCH-1:0]          lock_s;
    logic [NCH*BW-1:0]       lock_bin_s;
    logic [NW-1:0]           inband_n_s;
    logic [NW-1:0]           nonzero_n_s;
    logic [BW-1:0]           hit_bin_s;
    logic                    hit_nz_s;
    logic [CW-1:0]           bin_val_s;

`ifdef TRIG_EDGE_EN
    logic [NCH-1:0] prev_q, prev_d;

    // Previous trigger level; tracks every cycle so edges are seen at window start.
    always_comb begin
        if (resethist) begin
            prev_d = '0;
        end else begin
            prev_d = trig_in;
        end
    end

    // Previous-level register.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign samp_s = trig_in & ~prev_q;
`else
    assign samp_s = trig_in;
`endif

    // Working histogram update: clear on restart or window entry, count during ACQ.
    always_comb begin
        cnt_d  = cnt_q;
        satf_d = satf_q;
        if (resethist) begin
            cnt_d  = '0;
            satf_d = '0;
        end else if ((state_q == ST_GAP) && (pcnt_q == PCNT_MAX)) begin
            cnt_d  = '0;
            satf_d = '0;
        end else if (state_q == ST_ACQ) begin
            for (int c = 0; c < NCH; c++) begin
                if (samp_s[c]) begin
                    if (cnt_q[bin_base(c, int'(ph_q)) +: CW] == CNT_MAX) begin
                        satf_d[c] = 1'b1;
                    end else begin
                        cnt_d[bin_base(c, int'(ph_q)) +: CW] =
                            cnt_q[bin_base(c, int'(ph_q)) +: CW] + CNT_ONE;
                        // Reaching the ceiling counts as saturating the bin.
                        if (cnt_q[bin_base(c, int'(ph_q)) +: CW] == (CNT_MAX - CNT_ONE)) begin
                            satf_d[c] = 1'b1;
                        end else begin
                            satf_d[c] = satf_q[c];
                        end
                    end
                end else begin
                    satf_d[c] = satf_q[c];
                end
            end
        end else begin
            cnt_d  = cnt_q;
            satf_d = satf_q;
        end
    end

    // Lock evaluation: exactly one bin in the expected band, all others empty.
    always_comb begin
        lock_s      = '0;
        lock_bin_s  = '0;
        inband_n_s  = '0;
        nonzero_n_s = '0;
        hit_bin_s   = '0;
        hit_nz_s    = 1'b0;
        bin_val_s   = '0;
        for (int c = 0; c < NCH; c++) begin
            inband_n_s  = '0;
            nonzero_n_s = '0;
            hit_bin_s   = '0;
            hit_nz_s    = 1'b0;
            for (int b = 0; b < NBINS; b++) begin
                bin_val_s = cnt_q[bin_base(c, b) +: CW];
                if (bin_val_s != '0) begin
                    nonzero_n_s = nonzero_n_s + NW'(1);
                end else begin
                    nonzero_n_s = nonzero_n_s;
                end
                if ((bin_val_s >= BAND_LO) && (bin_val_s <= BAND_HI)) begin
                    inband_n_s = inband_n_s + NW'(1);
                    hit_bin_s  = BW'(b);
                    hit_nz_s   = (bin_val_s != '0);
                end else begin
                    inband_n_s = inband_n_s;
                end
            end
            // The in-band bin may itself be the only nonzero one.
            if ((inband_n_s == NW'(1)) && (nonzero_n_s == NW'(hit_nz_s))) begin
                lock_s[c]             = 1'b1;
                lock_bin_s[c*BW +: BW] = hit_bin_s;
            end else begin
                lock_s[c]             = 1'b0;
                lock_bin_s[c*BW +: BW] = '0;
            end
        end
    end

    // Sequencer next state, free-running counters and publish logic.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q + PERIOD_LOG2'(1);
        ph_d       = ph_q + BW'(1);
        done_d     = 1'b0;
        hist_d     = hist_q;
        lock_d     = lock_q;
        lock_bin_d = lock_bin_q;
        sat_d      = sat_q;
        if (resethist) begin
            state_d    = ST_ACQ;
            pcnt_d     = '0;
            ph_d       = '0;
            hist_d     = '0;
            lock_d     = '0;
            lock_bin_d = '0;
            sat_d      = '0;
        end else begin
            case (state_q)
                ST_ACQ: begin
                    if (pcnt_q == WIN_LAST) begin
                        state_d = ST_EVAL;
                    end else begin
                        state_d = ST_ACQ;
                    end
                end
                ST_EVAL: begin
                    state_d    = ST_GAP;
                    done_d     = 1'b1;
                    hist_d     = cnt_q;
                    lock_d     = lock_s;
                    lock_bin_d = lock_bin_s;
                    sat_d      = satf_q;
                end
                ST_GAP: begin
                    if (pcnt_q == PCNT_MAX) begin
                        state_d = ST_ACQ;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                default: begin
                    // Unreachable encoding: realign to a fresh period.
                    state_d = ST_ACQ;
                    pcnt_d  = '0;
                end
            endcase
        end
        window_d = (state_d == ST_ACQ);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_ACQ;
            pcnt_q     <= '0;
            ph_q       <= '0;
            cnt_q      <= '0;
            satf_q     <= '0;
            window_q   <= 1'b1;
            done_q     <= 1'b0;
            hist_q     <= '0;
            lock_q     <= '0;
            lock_bin_q <= '0;
            sat_q      <= '0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            satf_q     <= satf_d;
            window_q   <= window_d;
            done_q     <= done_d;
            hist_q     <= hist_d;
            lock_q     <= lock_d;
            lock_bin_q <= lock_bin_d;
            sat_q      <= sat_d;
        end
    end

    assign window   = window_q;
    assign done     = done_q;
    assign hist_out = hist_q;
    assign lock     = lock_q;
    assign lock_bin = lock_bin_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_trig_phase_hist.sv
// -----------------------------------------------------------------------------
// Self-checking bench for trig_phase_hist.
// dut_a: NCH=2 NBINS=4 CW=8 PERIOD_LOG2=6 WINDOW_LEN=16 band 3..5
// dut_b: same but CW=2 and band 3..3 (saturation case)
// A behavioural model tracks cycles since restart and rebuilds the histograms
// from the trigger pattern; a compare process checks every negedge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trig_phase_hist;

    localparam int NCH   = 2;
    localparam int NBINS = 4;
    localparam int WL    = 16;
    localparam int PER   = 64;

    logic        clk_adc = 1'b0;
    logic        nrst;
    logic        resethist;
    logic [1:0]  trig_a, trig_b;
    logic        window_a, done_a, window_b, done_b;
    logic [63:0] hist_a;
    logic [15:0] hist_b;
    logic [1:0]  lock_a, lock_b, sat_a, sat_b;
    logic [3:0]  lb_a, lb_b;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;
    int mode_a   = 0;
    int mode_b   = 0;

    always #5 clk_adc = ~clk_adc;

    trig_phase_hist #(
        .NCH(2), .NBINS(4), .CW(8), .PERIOD_LOG2(6),
        .WINDOW_LEN(16), .EXPECT_LO(3), .EXPECT_HI(5)
    ) dut_a (
        .clk_adc(clk_adc), .nrst(nrst), .trig_in(trig_a), .resethist(resethist),
        .window(window_a), .done(done_a), .hist_out(hist_a), .lock(lock_a),
        .lock_bin(lb_a), .sat(sat_a)
    );

    trig_phase_hist #(
        .NCH(2), .NBINS(4), .CW(2), .PERIOD_LOG2(6),
        .WINDOW_LEN(16), .EXPECT_LO(3), .EXPECT_HI(3)
    ) dut_b (
        .clk_adc(clk_adc), .nrst(nrst), .trig_in(trig_b), .resethist(resethist),
        .window(window_b), .done(done_b), .hist_out(hist_b), .lock(lock_b),
        .lock_bin(lb_b), .sat(sat_b)
    );

    // ---------------- behavioural model ----------------
    int  t;                         // cycles since last restart
    int  mc   [2][NCH][NBINS];      // working counts
    bit  ms   [2][NCH];
    bit  prv  [2][NCH];
    int  eh   [2][NCH][NBINS];      // published counts
    bit  el   [2][NCH];
    int  eb   [2][NCH];
    bit  es   [2][NCH];
    bit  ed;
    int  cmax [2] = '{255, 3};
    int  elo  [2] = '{3, 3};
    int  ehi  [2] = '{5, 3};
    logic [1:0] tr [2];

    always_comb begin
        tr[0] = trig_a;
        tr[1] = trig_b;
    end

    function automatic bit ev(input int d, input int c);
`ifdef TRIG_EDGE_EN
        return (tr[d][c] == 1'b1) && !prv[d][c];
`else
        return tr[d][c] == 1'b1;
`endif
    endfunction

    // Bin index a channel locks to, or -1.
    function automatic int model_lock(input int d, input int c);
        int nz;
        int bin;
        nz  = 0;
        bin = 0;
        for (int b = 0; b < NBINS; b++) begin
            if (mc[d][c][b] != 0) begin
                nz++;
                bin = b;
            end
        end
        if (nz != 1) return -1;
        if (mc[d][c][bin] >= elo[d] && mc[d][c][bin] <= ehi[d]) return bin;
        return -1;
    endfunction

    task automatic model_clear();
        t  <= 0;
        ed <= 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                ms[d][c]  <= 1'b0;
                prv[d][c] <= 1'b0;
                el[d][c]  <= 1'b0;
                eb[d][c]  <= 0;
                es[d][c]  <= 1'b0;
                for (int b = 0; b < NBINS; b++) begin
                    mc[d][c][b] <= 0;
                    eh[d][c][b] <= 0;
                end
            end
        end
    endtask

    always @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            model_clear();
        end else if (resethist) begin
            model_clear();
        end else begin
            t  <= t + 1;
            ed <= ((t % PER) == WL);
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NCH; c++) begin
                    prv[d][c] <= tr[d][c];
                    if ((t % PER) < WL) begin
                        if (ev(d, c)) begin
                            if (mc[d][c][t % NBINS] < cmax[d])
                                mc[d][c][t % NBINS] <= mc[d][c][t % NBINS] + 1;
                            if (mc[d][c][t % NBINS] + 1 >= cmax[d])
                                ms[d][c] <= 1'b1;
                        end
                    end else if ((t % PER) == WL) begin
                        for (int b = 0; b < NBINS; b++) eh[d][c][b] <= mc[d][c][b];
                        es[d][c] <= ms[d][c];
                        el[d][c] <= (model_lock(d, c) >= 0);
                        eb[d][c] <= (model_lock(d, c) >= 0) ? model_lock(d, c) : 0;
                    end else if ((t % PER) == PER - 1) begin
                        ms[d][c] <= 1'b0;
                        for (int b = 0; b < NBINS; b++) mc[d][c][b] <= 0;
                    end
                end
            end
        end
    end

    logic [63:0] xh_a;
    logic [15:0] xh_b;
    logic [1:0]  xl_a, xl_b, xs_a, xs_b;
    logic [3:0]  xb_a, xb_b;

    always_comb begin
        xh_a = '0; xh_b = '0;
        xl_a = '0; xl_b = '0; xs_a = '0; xs_b = '0;
        xb_a = '0; xb_b = '0;
        for (int c = 0; c < NCH; c++) begin
            xl_a[c] = el[0][c];
            xl_b[c] = el[1][c];
            xs_a[c] = es[0][c];
            xs_b[c] = es[1][c];
            xb_a[c*2 +: 2] = 2'(eb[0][c]);
            xb_b[c*2 +: 2] = 2'(eb[1][c]);
            for (int b = 0; b < NBINS; b++) begin
                xh_a[(c*NBINS+b)*8 +: 8] = 8'(eh[0][c][b]);
                xh_b[(c*NBINS+b)*2 +: 2] = 2'(eh[1][c][b]);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got 0x%0h want 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk_adc) begin
        if (cmp_en) begin
            chk("window_a", 64'(window_a), 64'((t % PER) < WL));
            chk("window_b", 64'(window_b), 64'((t % PER) < WL));
            chk("done_a",   64'(done_a),   64'(ed));
            chk("done_b",   64'(done_b),   64'(ed));
            chk("hist_a",   hist_a,        xh_a);
            chk("hist_b",   64'(hist_b),   64'(xh_b));
            chk("lock_a",   64'(lock_a),   64'(xl_a));
            chk("lock_b",   64'(lock_b),   64'(xl_b));
            chk("lockbin_a", 64'(lb_a),    64'(xb_a));
            chk("lockbin_b", 64'(lb_b),    64'(xb_b));
            chk("sat_a",    64'(sat_a),    64'(xs_a));
            chk("sat_b",    64'(sat_b),    64'(xs_b));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [1:0] pat(input int m, input int tt);
        int ph;
        ph = tt % NBINS;
        case (m)
            1:       return {1'b0, ph == 2};
            2:       return {1'b0, (ph == 2) || (ph == 3)};
            3:       return {ph == 3, 1'b1};
            4:       return {1'b0, ph == 1};
            default: return 2'b00;
        endcase
    endfunction

    task automatic drive();
        trig_a = pat(mode_a, t);
        trig_b = pat(mode_b, t);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk_adc);
            drive();
        end
    endtask

    task automatic wait_done(input string nm, input int exp_n);
        int n;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (done_a !== 1'b1 && n < 100);
        chk(nm, 64'(n), 64'(exp_n));
    endtask

    task automatic wait_t(input int x);
        int n;
        n = 0;
        while ((t % PER) != x && n < 200) begin
            cyc(1);
            n++;
        end
        chk("wait_pcnt", 64'(t % PER), 64'(x));
    endtask

    initial begin
        nrst      = 1'b0;
        resethist = 1'b0;
        trig_a    = 2'b00;
        trig_b    = 2'b00;
        repeat (3) @(negedge clk_adc);
        cmp_en = 1'b1;
        chk("rst_window", 64'(window_a), 64'd1);
        chk("rst_done",   64'(done_a),   64'd0);
        chk("rst_hist",   hist_a,        64'd0);
        chk("rst_lock",   64'(lock_a),   64'd0);

        // Single-phase lock on dut_a, saturation on dut_b.
        nrst   = 1'b1;
        mode_a = 1;
        mode_b = 4;
        drive();
        wait_done("first_done_edges", 17);
        chk("single_ch0_bins", 64'(hist_a[31:0]),  64'h0004_0000);
        chk("single_ch1_bins", 64'(hist_a[63:32]), 64'h0);
        chk("single_lock",     64'(lock_a),        64'b01);
        chk("single_lock_bin", 64'(lb_a),          64'b0010);
        chk("sat_bins",        64'(hist_b[7:0]),   64'h0C);
        chk("sat_flag",        64'(sat_b),         64'b01);
        chk("sat_lock",        64'(lock_b),        64'b01);
        chk("sat_lock_bin",    64'(lb_b),          64'b0001);
        chk("nosat_a",         64'(sat_a),         64'b00);

        // Straddling pulse; also measures period.
        mode_a = 2;
        wait_done("period_edges", 64);
        chk("straddle_bins", 64'(hist_a[31:0]), 64'h0404_0000);
        chk("straddle_lock", 64'(lock_a[0]),    64'd0);
        chk("straddle_lb",   64'(lb_a[1:0]),    64'd0);

        // Constant high on ch0, single-phase ch1.
        mode_a = 3;
        wait_done("period_edges2", 64);
`ifndef TRIG_EDGE_EN
        chk("const_bins",   64'(hist_a[31:0]),  64'h0404_0404);
        chk("ch1_bins",     64'(hist_a[63:32]), 64'h0400_0000);
        chk("const_lock",   64'(lock_a),        64'b10);
        chk("const_lb",     64'(lb_a),          64'b1100);
`endif

        // resethist mid-window.
        mode_a = 1;
        wait_t(10);
        resethist = 1'b1;
        cyc(1);
        resethist = 1'b0;
        chk("rh_window", 64'(window_a), 64'd1);
        chk("rh_done",   64'(done_a),   64'd0);
        chk("rh_hist",   hist_a,        64'd0);
        chk("rh_lock",   64'(lock_a),   64'd0);
        chk("rh_lb",     64'(lb_a),     64'd0);
        chk("rh_sat_b",  64'(sat_b),    64'd0);
        chk("rh_hist_b", 64'(hist_b),   64'd0);
        wait_done("rh_done_edges", 17);
        chk("rh_bins", 64'(hist_a[31:0]), 64'h0004_0000);

        // resethist during EVAL suppresses the publish.
        wait_t(16);
        resethist = 1'b1;
        cyc(1);
        resethist = 1'b0;
        chk("evalrh_done", 64'(done_a), 64'd0);
        chk("evalrh_hist", hist_a,      64'd0);
        wait_done("evalrh_next_edges", 17);

        // Asynchronous reset mid-window.
        wait_t(8);
        #2 nrst = 1'b0;
        #1;
        chk("nrst_window", 64'(window_a), 64'd1);
        chk("nrst_done",   64'(done_a),   64'd0);
        chk("nrst_hist",   hist_a,        64'd0);
        chk("nrst_lock",   64'(lock_a),   64'd0);
        chk("nrst_sat_b",  64'(sat_b),    64'd0);
        @(negedge clk_adc);
        nrst = 1'b1;
        drive();
        wait_done("nrst_done_edges", 17);
        chk("nrst_bins", 64'(hist_a[31:0]), 64'h0004_0000);

        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
